z80bd_int_ctrl: RTL
===================

Z80BD_INT_CTRL -- requirements
Module: z80bd_int_ctrl

Interface
REQ-001 The block SHALL have parameter TIMER_DIV, default 480000, timer tick period in CLK_24MHz cycles (50 Hz).
REQ-002 The block SHALL have parameter CTRL_PORT, default 8'h30, I/O address of the mask/status register.
REQ-003 The block SHALL have parameter VEC_PORT, default 8'h31, I/O address of the vector base register.
REQ-004 The block SHALL use one clock, CLK_24MHz, and a synchronous active-high reset, RES; Ports: CLK_24MHz  in  1  main clock.
REQ-005 RES  in  1  synchronous active-high reset.
REQ-006 IORQ, M1, RD, WR  in  1 each  Z80 strobes, active-low, asynchronous to CLK_24MHz.
REQ-007 A  in  8  Z80 address A[7:0].
REQ-008 D_IN  in  8  Z80 data bus, as driven by the CPU.
REQ-009 U_INT  in  1  16550 interrupt, active-high, level.
REQ-010 EXT_INT  in  1  external request, active-high, asynchronous, edge-triggered.
REQ-011 INT  out  1  Z80 maskable interrupt, active-low.
REQ-012 D_OUT  out  8  read/vector data for the top-level tristate.
REQ-013 D_OE  out  1  high = top level drives D_OUT onto D.

Function
REQ-014 IORQ, M1, RD, WR, EXT_INT SHALL each pass through a 2-flop synchronizer; A and D_IN SHALL be sampled unsynchronized at the write-strobe cycle.
REQ-015 An I/O write SHALL be detected on the first cycle where synchronized (IORQ=0 & WR=0) is true after being false; the register write SHALL take effect on the next cycle.
REQ-016 Write to CTRL_PORT SHALL load MASK[2:0] <= D_IN[2:0]; write to VEC_PORT SHALL load VBASE[7:3] <= D_IN[7:3]; other addresses are ignored.
REQ-017 D_OE SHALL be combinational from raw inputs: high when IORQ=0 & RD=0 & M1=1 & A in {CTRL_PORT, VEC_PORT}, or IORQ=0 & M1=0 (acknowledge).
REQ-018 Read data: CTRL_PORT -> {1'b0, PEND[2:0], 1'b0, MASK[2:0]}; VEC_PORT -> {VBASE[7:3], 3'b000}.
REQ-019 Sources: 0 = U_INT (level, PEND[0] = U_INT), 1 = timer (edge-latched), 2 = EXT_INT (rising edge of synchronized input, latched).
REQ-020 Timer counter SHALL count 0..TIMER_DIV-1 and wrap; on wrap PEND[1] SHALL be set, independent of MASK.
REQ-021 Priority fixed: source 0 > 1 > 2; REQ_V = PEND & MASK.
REQ-022 FSM states IDLE, ASSERT, ACK.
REQ-023 IDLE: if REQ_V != 0, latch SRC = highest-priority index, INT <= 0, -> ASSERT.
REQ-024 ASSERT: SRC frozen; on synchronized (M1=0 & IORQ=0) -> ACK, INT <= 1, clear PEND[SRC] if SRC is 1 or 2.
REQ-025 ASSERT: if REQ_V[SRC] drops (source withdrawn or masked) with no ack that cycle -> IDLE, INT <= 1; ack in the same cycle wins.
REQ-026 ACK: stay until synchronized IORQ=1, then -> IDLE; INT SHALL stay high for at least one cycle before reassertion.
REQ-027 Acknowledge vector on D_OUT = {VBASE[7:3], SRC[1:0], 1'b0}; an acknowledge seen in IDLE (spurious) SHALL use SRC = 2'b11.
REQ-028 A new timer/EXT event in the same cycle as its ACK clear SHALL leave PEND set.
REQ-029 MASK written in the same cycle as a new request SHALL apply from the next cycle.

Reset
REQ-030 On RES=1 at a clock edge: state IDLE, INT=1, MASK=0, VBASE=0, PEND[2:1]=0, SRC=0, timer count=0, synchronizers and edge detectors cleared.
REQ-031 D_OE follows REQ-017 during reset; reset mid-ASSERT/ACK SHALL release INT on the next cycle.

Verification
REQ-032 Write 0x07 to 0x30, 0xA0 to 0x31, read 0x30 -> D_OUT=0x07, D_OE=1; read 0x31 -> 0xA0.
REQ-033 MASK=0x01, U_INT=1 -> INT=0 within 4 cycles; ack (M1=0, IORQ=0) -> D_OUT=0xA0, INT=1; U_INT still 1 -> INT re-asserts after IORQ rises.
REQ-034 MASK=0x07, EXT_INT and timer pending together, U_INT=0 -> first ack vector 0xA2, second 0xA4; PEND reads 0 afterwards.
REQ-035 TIMER_DIV=10, MASK=0x00 -> PEND[1] sets after 10 cycles, INT stays 1; write MASK=0x02 -> INT=0.
REQ-036 In ASSERT with SRC=0, drop U_INT -> INT=1, state IDLE; ack in IDLE -> vector 0xA6.
REQ-037 RES=1 during ASSERT -> next cycle INT=1, read 0x30 returns 0x00 with U_INT=0.

Source files
------------

// File: rtl/z80bd_int_ctrl.sv
// Three-source interrupt controller for the Z80 board: UART level, 50 Hz timer, external edge.
// Supplies the acknowledge vector and the mask/status and vector-base register reads.
module z80bd_int_ctrl #(
   parameter int unsigned TIMER_DIV = 480000,
   parameter logic [7:0]  CTRL_PORT = 8'h30,
   parameter logic [7:0]  VEC_PORT  = 8'h31
) (
   input  logic       CLK_24MHz,
   input  logic       RES,
   input  logic       IORQ,
   input  logic       M1,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] A,
   input  logic [7:0] D_IN,
   input  logic       U_INT,
   input  logic       EXT_INT,
   output logic       INT,
   output logic [7:0] D_OUT,
   output logic       D_OE
);

   localparam int unsigned      CNT_W   = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMER_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ASSERT = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   // Lowest set index wins: UART, then timer, then external.
   function automatic logic [1:0] prio_idx(input logic [2:0] req);
      logic [1:0] idx;
      idx = 2'd0;
      if (req[0]) begin
         idx = 2'd0;
      end else if (req[1]) begin
         idx = 2'd1;
      end else if (req[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

   logic [1:0]       iorq_sync_r, m1_sync_r, rd_sync_r, wr_sync_r, ext_sync_r;
   logic             ext_prev_r, wr_prev_r, wr_go_r;
   logic [7:0]       wr_addr_r, wr_data_r;
   logic [2:0]       mask_r;
   logic [4:0]       vbase_r;
   logic [2:1]       pend_r;
   logic [1:0]       state_r, src_r;
   logic             int_r;
   logic [CNT_W-1:0] cnt_r;

   logic       iorq_s, m1_s, rd_s, wr_s, ext_s;
   logic       wr_strobe_s, ack_s, ack_go_s, tick_s, ext_rise_s;
   logic [2:0] pend_s, req_v_s;
   logic [2:1] clr_s;
   logic [1:0] vec_src_s;
   logic       ack_raw_s, rd_raw_s;

   assign iorq_s = iorq_sync_r[1];
   assign m1_s   = m1_sync_r[1];
   assign rd_s   = rd_sync_r[1];
   assign wr_s   = wr_sync_r[1];
   assign ext_s  = ext_sync_r[1];

   // RD low alongside WR is not a legal bus cycle and is not treated as a write.
   assign wr_strobe_s = ~iorq_s & ~wr_s & rd_s & ~wr_prev_r;
   assign ack_s       = ~m1_s & ~iorq_s;
   assign ack_go_s    = (state_r == ST_ASSERT) & ack_s;
   assign tick_s      = (cnt_r == CNT_MAX);
   assign ext_rise_s  = ext_s & ~ext_prev_r;
   assign pend_s      = {pend_r[2], pend_r[1], U_INT};
   assign req_v_s     = pend_s & mask_r;
   assign clr_s[1]    = ack_go_s & (src_r == 2'd1);
   assign clr_s[2]    = ack_go_s & (src_r == 2'd2);

   // Strobe/EXT synchronizers; strobes clear to their inactive (high) level.
   always_ff @(posedge CLK_24MHz) begin
      if (RES) begin
         iorq_sync_r <= 2'b11;
         m1_sync_r   <= 2'b11;
         rd_sync_r   <= 2'b11;
         wr_sync_r   <= 2'b11;
         ext_sync_r  <= 2'b00;
         ext_prev_r  <= 1'b0;
         wr_prev_r   <= 1'b0;
      end else begin
         iorq_sync_r <= {iorq_sync_r[0], IORQ};
         m1_sync_r   <= {m1_sync_r[0], M1};
         rd_sync_r   <= {rd_sync_r[0], RD};
         wr_sync_r   <= {wr_sync_r[0], WR};
         ext_sync_r  <= {ext_sync_r[0], EXT_INT};
         ext_prev_r  <= ext_s;
         wr_prev_r   <= ~iorq_s & ~wr_s;
      end
   end

   // Capture address/data at the write strobe, commit to the registers one cycle later.
   always_ff @(posedge CLK_24MHz) begin
      if (RES) begin
         wr_go_r   <= 1'b0;
         wr_addr_r <= 8'h00;
         wr_data_r <= 8'h00;
         mask_r    <= 3'b000;
         vbase_r   <= 5'b00000;
      end else begin
         wr_go_r <= wr_strobe_s;
         if (wr_strobe_s) begin
            wr_addr_r <= A;
            wr_data_r <= D_IN;
         end
         if (wr_go_r) begin
            if (wr_addr_r == CTRL_PORT) begin
               mask_r <= wr_data_r[2:0];
            end else if (wr_addr_r == VEC_PORT) begin
               vbase_r <= wr_data_r[7:3];
            end
         end
      end
   end

   // Free-running tick timer and latched pending bits; a new event beats a same-cycle clear.
   always_ff @(posedge CLK_24MHz) begin
      if (RES) begin
         cnt_r  <= '0;
         pend_r <= 2'b00;
      end else begin
         cnt_r     <= tick_s ? '0 : cnt_r + CNT_ONE;
         pend_r[1] <= tick_s | (pend_r[1] & ~clr_s[1]);
         pend_r[2] <= ext_rise_s | (pend_r[2] & ~clr_s[2]);
      end
   end

   // Request/acknowledge sequencer driving INT.
   always_ff @(posedge CLK_24MHz) begin
      if (RES) begin
         state_r <= ST_IDLE;
         src_r   <= 2'd0;
         int_r   <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_v_s != 3'b000) begin
                  src_r   <= prio_idx(req_v_s);
                  int_r   <= 1'b0;
                  state_r <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (ack_s) begin
                  int_r   <= 1'b1;
                  state_r <= ST_ACK;
               end else if (!req_v_s[src_r]) begin
                  int_r   <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            ST_ACK: begin
               int_r <= 1'b1;
               if (iorq_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               int_r   <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign INT = int_r;

   // Bus-facing read/vector mux, decoded from the raw strobes so the CPU sees data in the same cycle.
   always_comb begin
      ack_raw_s = ~IORQ & ~M1;
      rd_raw_s  = ~IORQ & ~RD & M1 & ((A == CTRL_PORT) | (A == VEC_PORT));
      vec_src_s = (state_r == ST_IDLE) ? 2'b11 : src_r;
      D_OE      = ack_raw_s | rd_raw_s;
      D_OUT     = 8'h00;
      if (ack_raw_s) begin
         D_OUT = {vbase_r, vec_src_s, 1'b0};
      end else if (A == CTRL_PORT) begin
         D_OUT = {1'b0, pend_s, 1'b0, mask_r};
      end else if (A == VEC_PORT) begin
         D_OUT = {vbase_r, 3'b000};
      end else begin
         D_OUT = 8'h00;
      end
   end

endmodule
